// File: rtl/sigma_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sigma_arb_pkg
// Brief    : Shared types and constants for the two-master sigma bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sigma_arb_pkg;

    localparam int NUM_MASTERS    = 2;
    localparam int c_xif_addr_w   = 32;
    localparam int c_xif_data_w   = 32;

    // Master identifier: 0 = CPU data port, 1 = UART debug master
    typedef logic mid_t;

    // Request fields carried alongside req; sized for the default bus widths
    typedef struct packed {
        logic                        we;
        logic [c_xif_addr_w-1:0]     addr;
        logic [c_xif_data_w/8-1:0]   be;
        logic [c_xif_data_w-1:0]     wdata;
    } xif_req_t;

endpackage
`default_nettype wire

// File: rtl/sigma_arb_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sigma_arb_id_fifo
// Brief    : Ordered FIFO of master IDs for reads awaiting a slave response.
// Revision : 1.0 - initial release
// ============================================================================
module sigma_arb_id_fifo
    import sigma_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  mid_t                     i_din,
    input  logic                     i_pop,
    output mid_t                     o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                 c_ptr_w    = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_ptr_w:0]   c_cnt_one  = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w:0]   c_cnt_full = (c_ptr_w + 1)'(DEPTH);

    mid_t               r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == c_cnt_full);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    // Guards make the FIFO safe even if a caller ignores full/empty
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop  & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sigma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sigma_bus_arbiter
// Brief    : Round-robin two-master arbiter for one sigma xif slave port.
// Revision : 1.0 - initial release
// ============================================================================
module sigma_bus_arbiter
    import sigma_arb_pkg::*;
#(
    parameter int ADDR_W  = c_xif_addr_w,
    parameter int DATA_W  = c_xif_data_w,
    parameter int MAX_OUT = 4
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic                m0_ack_o,
    output logic                m0_resp_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic                m1_ack_o,
    output logic                m1_resp_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                s_req_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W/8-1:0] s_be_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    input  logic                s_ack_i,
    input  logic                s_resp_i,
    input  logic [DATA_W-1:0]   s_rdata_i,
    output logic                err_o
);

    localparam int c_cnt_w = $clog2(MAX_OUT) + 1;

    xif_req_t                 w_m_req [NUM_MASTERS];
    logic [NUM_MASTERS-1:0]   w_req;
    xif_req_t                 w_s_fields;
    logic                     w_gnt_valid;
    mid_t                     w_gnt_id;
    logic                     w_mask;
    logic                     w_s_req;
    logic                     w_accept;
    logic                     w_pop;
    logic                     w_spurious;
    mid_t                     w_head_id;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [c_cnt_w-1:0]       w_fifo_count;

    mid_t                     r_rr_ptr;
    logic                     r_lock;
    mid_t                     r_lock_id;
    logic                     r_err;

    assign w_m_req[0] = '{we: m0_we_i, addr: m0_addr_i, be: m0_be_i, wdata: m0_wdata_i};
    assign w_m_req[1] = '{we: m1_we_i, addr: m1_addr_i, be: m1_be_i, wdata: m1_wdata_i};
    assign w_req      = {m1_req_i, m0_req_i};

    // A stalled request owns the bus until the slave takes it
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_id    = r_rr_ptr;
        if (r_lock) begin
            w_gnt_valid = 1'b1;
            w_gnt_id    = r_lock_id;
        end else if (w_req[r_rr_ptr]) begin
            w_gnt_valid = 1'b1;
            w_gnt_id    = r_rr_ptr;
        end else if (w_req[~r_rr_ptr]) begin
            w_gnt_valid = 1'b1;
            w_gnt_id    = ~r_rr_ptr;
        end
        if (!arst_n_i) begin
            w_gnt_valid = 1'b0;
        end
    end

    // Reads wait while every response slot is taken; the registered count
    // means a same-cycle pop does not free a slot until the next cycle
    assign w_mask     = w_gnt_valid & ~w_m_req[w_gnt_id].we & w_fifo_full;
    assign w_s_req    = w_gnt_valid & ~w_mask;
    assign w_accept   = w_s_req & s_ack_i;
    assign w_s_fields = w_s_req ? w_m_req[w_gnt_id] : '0;

    assign s_req_o   = w_s_req;
    assign s_we_o    = w_s_fields.we;
    assign s_addr_o  = w_s_fields.addr;
    assign s_be_o    = w_s_fields.be;
    assign s_wdata_o = w_s_fields.wdata;

    assign m0_ack_o  = w_accept & (w_gnt_id == 1'b0);
    assign m1_ack_o  = w_accept & (w_gnt_id == 1'b1);

    assign w_pop      = s_resp_i & ~w_fifo_empty;
    assign w_spurious = s_resp_i & (w_fifo_count == '0);

    assign m0_resp_o  = w_pop & (w_head_id == 1'b0);
    assign m1_resp_o  = w_pop & (w_head_id == 1'b1);
    assign m0_rdata_o = m0_resp_o ? s_rdata_i : '0;
    assign m1_rdata_o = m1_resp_o ? s_rdata_i : '0;
    assign err_o      = r_err;

    sigma_arb_id_fifo #(
        .DEPTH   (MAX_OUT)
    ) u_id_fifo (
        .clk     (clk_i),
        .rst_n   (arst_n_i),
        .i_push  (w_accept & ~w_m_req[w_gnt_id].we),
        .i_din   (w_gnt_id),
        .i_pop   (w_pop),
        .o_dout  (w_head_id),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_rr_ptr  <= 1'b0;
            r_lock    <= 1'b0;
            r_lock_id <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_lock <= w_s_req & ~s_ack_i;
            if (w_s_req & ~s_ack_i) begin
                r_lock_id <= w_gnt_id;
            end
            if (w_accept) begin
                r_rr_ptr <= ~w_gnt_id;
            end
            if (w_spurious) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sigma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sigma_bus_arbiter
// Brief    : Directed vector table, corner sequences and randomized model run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sigma_bus_arbiter;
    import sigma_arb_pkg::*;

    localparam int          MAX_OUT = 4;
    localparam logic [31:0] c_a0 = 32'h0000_0100;
    localparam logic [31:0] c_a1 = 32'h0000_0200;
    localparam logic [31:0] c_d0 = 32'h0A0A_0A0A;
    localparam logic [31:0] c_d1 = 32'h0B0B_0B0B;
    localparam logic [3:0]  c_b0 = 4'hF;
    localparam logic [3:0]  c_b1 = 4'h3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o, s_we_o, s_ack_i, s_resp_i, err_o;
    logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
    logic [3:0]  s_be_o;

    int n_checks = 0;
    int n_pass   = 0;

    sigma_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(MAX_OUT)) dut (
        .clk_i(clk), .arst_n_i(arst_n_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_be_i(m0_be_i),
        .m0_wdata_i(m0_wdata_i), .m0_ack_o(m0_ack_o), .m0_resp_o(m0_resp_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_be_i(m1_be_i),
        .m1_wdata_i(m1_wdata_i), .m1_ack_o(m1_ack_o), .m1_resp_o(m1_resp_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_be_o(s_be_o),
        .s_wdata_o(s_wdata_o), .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_i(s_rdata_i),
        .err_o(err_o)
    );

    typedef struct {
        bit          r0, w0, r1, w1, ack, resp;
        logic [31:0] rd;
        int          gnt;
        logic [1:0]  eack, eresp;
        bit          eerr;
    } vec_t;

    vec_t tbl [14];

    // Expected output image for the fixed-field masters; gnt < 0 means idle bus
    function automatic logic [138:0] expv(input int gnt, input logic we, input logic [1:0] ack,
                                          input logic [1:0] resp, input logic [31:0] rd, input logic err);
        logic        sr = 1'b0, w = 1'b0;
        logic [31:0] a = '0, d = '0;
        logic [3:0]  b = '0;
        if (gnt == 0) begin sr = 1'b1; w = we; a = c_a0; b = c_b0; d = c_d0; end
        if (gnt == 1) begin sr = 1'b1; w = we; a = c_a1; b = c_b1; d = c_d1; end
        return {sr, w, a, b, d, ack, resp, resp[0] ? rd : 32'h0, resp[1] ? rd : 32'h0, err};
    endfunction

    task automatic check_vec(input string name, input logic [138:0] exp);
        logic [138:0] act;
        act = {s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o, m1_ack_o, m0_ack_o,
               m1_resp_o, m0_resp_o, m0_rdata_o, m1_rdata_o, err_o};
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cycle(input bit r0, w0, r1, w1, ack, resp, input logic [31:0] rd);
        @(negedge clk);
        m0_req_i = r0; m0_we_i = w0; m0_addr_i = c_a0; m0_be_i = c_b0; m0_wdata_i = c_d0;
        m1_req_i = r1; m1_we_i = w1; m1_addr_i = c_a1; m1_be_i = c_b1; m1_wdata_i = c_d1;
        s_ack_i = ack; s_resp_i = resp; s_rdata_i = rd;
        #1;
    endtask

    task automatic do_reset();
        arst_n_i = 1'b0;
        m0_req_i = 0; m0_we_i = 0; m0_addr_i = 0; m0_be_i = 0; m0_wdata_i = 0;
        m1_req_i = 0; m1_we_i = 0; m1_addr_i = 0; m1_be_i = 0; m1_wdata_i = 0;
        s_ack_i = 0; s_resp_i = 0; s_rdata_i = 0;
        repeat (2) @(posedge clk);
        #2 arst_n_i = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Random-phase reference state
    int          q[$];
    int          prio, stall_id, gnt;
    bit          stalled, masked, sr, acc, err_m;
    bit          pend [2];
    bit          pwe  [2];
    logic [31:0] pa [2], pd [2];
    logic [3:0]  pb [2];
    logic [1:0]  rsp, ackv;

    initial begin
        tbl[0]  = '{1,0,0,0,1,0,32'h0,        0, 2'b01, 2'b00, 0};
        tbl[1]  = '{0,0,0,0,0,0,32'h0,       -1, 2'b00, 2'b00, 0};
        tbl[2]  = '{0,0,0,0,0,1,32'hDEADBEEF,-1, 2'b00, 2'b01, 0};
        tbl[3]  = '{1,1,1,1,1,0,32'h0,        1, 2'b10, 2'b00, 0};
        tbl[4]  = '{1,1,1,1,1,0,32'h0,        0, 2'b01, 2'b00, 0};
        tbl[5]  = '{1,1,1,1,1,0,32'h0,        1, 2'b10, 2'b00, 0};
        tbl[6]  = '{0,0,1,0,0,0,32'h0,        1, 2'b00, 2'b00, 0};
        tbl[7]  = '{1,1,1,0,0,0,32'h0,        1, 2'b00, 2'b00, 0};
        tbl[8]  = '{1,1,1,0,0,0,32'h0,        1, 2'b00, 2'b00, 0};
        tbl[9]  = '{1,1,1,0,1,0,32'h0,        1, 2'b10, 2'b00, 0};
        tbl[10] = '{1,1,0,0,1,0,32'h0,        0, 2'b01, 2'b00, 0};
        tbl[11] = '{0,0,0,0,0,1,32'h12345678,-1, 2'b00, 2'b10, 0};
        tbl[12] = '{0,0,0,0,0,1,32'h0,       -1, 2'b00, 2'b00, 0};
        tbl[13] = '{0,0,0,0,0,0,32'h0,       -1, 2'b00, 2'b00, 1};

        arst_n_i = 1'b0;
        do_reset();
        arst_n_i = 1'b0;
        #1 check_vec("reset_state", expv(-1, 0, 2'b00, 2'b00, 32'h0, 0));
        @(posedge clk);
        #2 arst_n_i = 1'b1;

        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].r0, tbl[i].w0, tbl[i].r1, tbl[i].w1, tbl[i].ack, tbl[i].resp, tbl[i].rd);
            check_vec($sformatf("table[%0d]", i),
                      expv(tbl[i].gnt, (tbl[i].gnt == 0) ? tbl[i].w0 : tbl[i].w1,
                           tbl[i].eack, tbl[i].eresp, tbl[i].rd, tbl[i].eerr));
        end

        // Asynchronous reset in the middle of a stalled read
        cycle(1, 0, 0, 0, 0, 0, 32'h0);
        check_vec("stall_before_reset", expv(0, 0, 2'b00, 2'b00, 32'h0, 1));
        #2 arst_n_i = 1'b0;
        m1_req_i = 1'b1; s_resp_i = 1'b1; s_rdata_i = 32'h5A5A5A5A;
        #1 check_vec("in_reset_outputs", expv(-1, 0, 2'b00, 2'b00, 32'h0, 0));
        @(posedge clk);
        #2 arst_n_i = 1'b1;
        cycle(1, 1, 1, 1, 1, 0, 32'h0);
        check_vec("m0_priority_after_reset", expv(0, 1, 2'b01, 2'b00, 32'h0, 0));
        cycle(0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
        check_vec("stale_resp_dropped", expv(-1, 0, 2'b00, 2'b00, 32'h0, 0));
        cycle(0, 0, 0, 0, 0, 0, 32'h0);
        check_vec("stale_resp_err", expv(-1, 0, 2'b00, 2'b00, 32'h0, 1));

        // Fill the response FIFO, then watch the fifth read wait for a slot
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cycle(k % 2 == 0, 0, k % 2 == 1, 0, 1, 0, 32'h0);
            check_vec($sformatf("fill[%0d]", k), expv(k % 2, 0, (k % 2) ? 2'b10 : 2'b01, 2'b00, 32'h0, 0));
        end
        for (int k = 0; k < 2; k++) begin
            cycle(1, 0, 0, 0, 1, 0, 32'h0);
            check_vec($sformatf("full_mask[%0d]", k), expv(-1, 0, 2'b00, 2'b00, 32'h0, 0));
        end
        cycle(1, 0, 0, 0, 1, 1, 32'h000000A1);
        check_vec("pop_at_full_still_masked", expv(-1, 0, 2'b00, 2'b01, 32'h000000A1, 0));
        cycle(1, 0, 0, 0, 1, 0, 32'h0);
        check_vec("fifth_read_accepted", expv(0, 0, 2'b01, 2'b00, 32'h0, 0));
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 0, 0, 1, 32'h000000B0 + 32'(k));
            check_vec($sformatf("drain[%0d]", k),
                      expv(-1, 0, 2'b00, (k % 2 == 0) ? 2'b10 : 2'b01, 32'h000000B0 + 32'(k), 0));
        end

        // Interleaved read/read/write; the write must not produce a response
        cycle(1, 0, 0, 0, 1, 0, 32'h0);
        check_vec("mix_m0_read", expv(0, 0, 2'b01, 2'b00, 32'h0, 0));
        cycle(0, 0, 1, 0, 1, 0, 32'h0);
        check_vec("mix_m1_read", expv(1, 0, 2'b10, 2'b00, 32'h0, 0));
        cycle(1, 1, 0, 0, 1, 1, 32'h00000055);
        check_vec("mix_m0_write_resp_m0", expv(0, 1, 2'b01, 2'b01, 32'h00000055, 0));
        cycle(0, 0, 0, 0, 0, 1, 32'h00000066);
        check_vec("mix_resp_m1", expv(-1, 0, 2'b00, 2'b10, 32'h00000066, 0));
        cycle(0, 0, 0, 0, 0, 0, 32'h0);
        check_vec("mix_idle", expv(-1, 0, 2'b00, 2'b00, 32'h0, 0));

        // Randomized traffic against a queue-based model of the arbitration rules
        do_reset();
        prio = 0; stalled = 0; stall_id = 0; err_m = 0;
        q.delete();
        for (int m = 0; m < 2; m++) begin pend[m] = 0; pwe[m] = 0; pa[m] = 0; pb[m] = 0; pd[m] = 0; end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && $urandom_range(1, 0) == 1) begin
                    pend[m] = 1; pwe[m] = 1'($urandom_range(1, 0));
                    pa[m] = $urandom; pb[m] = 4'($urandom); pd[m] = $urandom;
                end
            end
            m0_req_i = pend[0]; m0_we_i = pwe[0]; m0_addr_i = pa[0]; m0_be_i = pb[0]; m0_wdata_i = pd[0];
            m1_req_i = pend[1]; m1_we_i = pwe[1]; m1_addr_i = pa[1]; m1_be_i = pb[1]; m1_wdata_i = pd[1];
            s_ack_i   = ($urandom_range(9, 0) < 7);
            s_resp_i  = (q.size() > 0) && ($urandom_range(9, 0) < 3);
            s_rdata_i = $urandom;
            #1;
            gnt = -1;
            if (stalled) gnt = stall_id;
            else if (pend[prio]) gnt = prio;
            else if (pend[1 - prio]) gnt = 1 - prio;
            masked = (gnt >= 0) && !pwe[gnt] && (q.size() == MAX_OUT);
            sr     = (gnt >= 0) && !masked;
            acc    = sr && s_ack_i;
            ackv   = 2'b00;
            if (acc) ackv[gnt] = 1'b1;
            rsp = 2'b00;
            if (s_resp_i && q.size() > 0) rsp[q[0]] = 1'b1;
            check_vec($sformatf("random[%0d]", cyc),
                      {sr, sr ? pwe[gnt] : 1'b0, sr ? pa[gnt] : 32'h0, sr ? pb[gnt] : 4'h0,
                       sr ? pd[gnt] : 32'h0, ackv, rsp, rsp[0] ? s_rdata_i : 32'h0,
                       rsp[1] ? s_rdata_i : 32'h0, err_m});
            if (s_resp_i) begin
                if (q.size() > 0) void'(q.pop_front());
                else err_m = 1;
            end
            if (acc && !pwe[gnt]) q.push_back(gnt);
            if (acc) begin
                prio = 1 - gnt;
                pend[gnt] = 0;
            end
            stalled  = sr && !s_ack_i;
            stall_id = gnt;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
